// File: rtl/sd_usb_tx_fifo.sv
// rtl/sd_usb_tx_fifo.sv - SD-to-USB transmit byte FIFO with packet-ready and flush (option: TX_FIFO_FWFT_EN)
module sd_usb_tx_fifo #(
  parameter int DEPTH     = 64,
  parameter int PKT_BYTES = 64,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              w_enable,
  input  logic [7:0]        w_data,
  input  logic              flush,
  input  logic              r_enable,
  output logic [7:0]        r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              pkt_rdy,
  output logic              overrun,
  output logic              underrun
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PKT_CNT   = (ADDR_W+1)'(PKT_BYTES);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              flush_pend;
  logic              flush_pend_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic              wr_acc;
  logic              rd_acc;

  // Status flags come straight from the registered count.
  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // Accept decisions and next count / flush state; clear overrides everything.
  always_comb begin
    wr_acc    = w_enable && (!full || r_enable) && !clear;
    rd_acc    = r_enable && !empty && !clear;
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      count_nxt = count + 1'b1;
    end else if (!wr_acc && rd_acc) begin
      count_nxt = count - 1'b1;
    end
    flush_pend_nxt = flush_pend || (flush && (!empty || wr_acc));
    if (clear || (count_nxt == '0) || (count_nxt >= PKT_CNT)) begin
      flush_pend_nxt = 1'b0;
    end
  end

  // Byte storage; never reset or erased, only overwritten on accepted writes.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= w_data;
    end
  end

  // Pointers, count, flush tracking and registered status pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      flush_pend <= 1'b0;
      pkt_rdy    <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      end
      count      <= count_nxt;
      flush_pend <= flush_pend_nxt;
      pkt_rdy    <= (count_nxt >= PKT_CNT) || (flush_pend_nxt && (count_nxt != '0));
      overrun    <= !clear && w_enable && full && !r_enable;
      underrun   <= !clear && r_enable && empty;
    end
  end

`ifdef TX_FIFO_FWFT_EN
  // Head byte is presented combinationally; zero while nothing is stored.
  assign r_data = empty ? 8'h00 : mem[rd_ptr];
`else
  // Head byte is captured on each accepted read and held until the next one.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_data <= 8'h00;
    end else if (rd_acc) begin
      r_data <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sd_usb_tx_fifo.sv
// tb/tb_sd_usb_tx_fifo.sv - self-checking bench for sd_usb_tx_fifo against a queue model
module tb_sd_usb_tx_fifo;
  localparam int DEPTH = 64;
  localparam int PKT   = 64;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clear;
  logic       w_enable;
  logic [7:0] w_data;
  logic       flush;
  logic       r_enable;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic [6:0] count;
  logic       pkt_rdy;
  logic       overrun;
  logic       underrun;

  int checks   = 0;
  int failures = 0;

  byte unsigned q[$];
  bit           m_fp;
  bit           m_pkt;
  bit           m_ov;
  bit           m_un;
  logic [7:0]   m_rdata;

  sd_usb_tx_fifo #(.DEPTH(DEPTH), .PKT_BYTES(PKT)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .w_enable(w_enable), .w_data(w_data),
    .flush(flush), .r_enable(r_enable), .r_data(r_data), .empty(empty), .full(full),
    .count(count), .pkt_rdy(pkt_rdy), .overrun(overrun), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fp    = 1'b0;
    m_pkt   = 1'b0;
    m_ov    = 1'b0;
    m_un    = 1'b0;
    m_rdata = 8'h00;
  endtask

  task automatic check_all(input string ph);
    logic [7:0] exp_rd;
`ifdef TX_FIFO_FWFT_EN
    exp_rd = (q.size() == 0) ? 8'h00 : q[0];
`else
    exp_rd = m_rdata;
`endif
    chk({ph, ":count"},    count,    q.size());
    chk({ph, ":empty"},    empty,    q.size() == 0);
    chk({ph, ":full"},     full,     q.size() == DEPTH);
    chk({ph, ":pkt_rdy"},  pkt_rdy,  m_pkt);
    chk({ph, ":overrun"},  overrun,  m_ov);
    chk({ph, ":underrun"}, underrun, m_un);
    chk({ph, ":r_data"},   r_data,   exp_rd);
  endtask

  // One clock of stimulus; the model advances from the pre-edge state.
  task automatic step(input string ph, input bit w, input logic [7:0] d, input bit r,
                      input bit f, input bit c);
    int sz;
    bit wacc;
    bit racc;
    @(negedge clk);
    w_enable = w; w_data = d; r_enable = r; flush = f; clear = c;
    sz = q.size();
    if (c) begin
      q.delete();
      m_fp = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      wacc = w && (sz < DEPTH || r);
      racc = r && (sz > 0);
      m_ov = w && (sz == DEPTH) && !r;
      m_un = r && (sz == 0);
      if (racc) m_rdata = q.pop_front();
      if (wacc) q.push_back(d);
      if (f && (sz > 0 || wacc)) m_fp = 1'b1;
    end
    if (q.size() == 0 || q.size() >= PKT) m_fp = 1'b0;
    m_pkt = (q.size() >= PKT) || (m_fp && q.size() > 0);
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic push(input string ph, input logic [7:0] d);
    step(ph, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop(input string ph);
    step(ph, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; w_enable = 1'b0; w_data = 8'h00; flush = 1'b0; r_enable = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 10; i++) step("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 64; i++) push("fill64", 8'(i));
    chk("fill64:pkt_rdy_hi", pkt_rdy, 1'b1);
    chk("fill64:full_hi", full, 1'b1);
    for (int i = 0; i < 64; i++) begin
      pop("drain64");
`ifndef TX_FIFO_FWFT_EN
      chk("drain64:order", r_data, 8'(i));
`endif
    end
    chk("drain64:empty_hi", empty, 1'b1);

    for (int i = 0; i < 5; i++) push("tail5", 8'($urandom));
    step("flush", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("flush:pkt_rdy_hi", pkt_rdy, 1'b1);
    for (int i = 0; i < 5; i++) pop("tail_drain");
    chk("tail_drain:pkt_rdy_lo", pkt_rdy, 1'b0);
    step("flush_empty", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 64; i++) push("fill_ovr", 8'($urandom_range(0, 8'hA9)));
    step("overrun", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("overrun:pulse", overrun, 1'b1);
    step("overrun_rw", 1'b1, 8'hAB, 1'b1, 1'b0, 1'b0);
    chk("overrun_rw:count64", count, 7'd64);
    for (int i = 0; i < 64; i++) pop("drain_ovr");

    step("underrun", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("underrun:pulse", underrun, 1'b1);
    step("underrun_wr", 1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
    chk("underrun_wr:count1", count, 7'd1);
    pop("underrun_pop");

    for (int i = 0; i < 40; i++) push("pre_rst", 8'($urandom));
    @(negedge clk);
    w_enable = 1'b1; w_data = 8'h77;
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    w_enable = 1'b0;
    n_rst = 1'b1;

    for (int i = 0; i < 62; i++) begin
      push("walk", 8'($urandom));
      pop("walk");
    end
    for (int i = 0; i < 3; i++) push("wrap", 8'($urandom));
    for (int i = 0; i < 3; i++) pop("wrap");

    for (int i = 0; i < 10; i++) push("pre_clr", 8'($urandom));
    step("clear", 1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    chk("clear:count0", count, 7'd0);

    for (int blk = 0; blk < 20; blk++) begin
      int wp;
      wp = (blk % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 100; i++) begin
        step("rand",
             ($urandom_range(0, 99) < wp),
             8'($urandom),
             ($urandom_range(0, 99) < 100 - wp),
             ($urandom_range(0, 99) < 5),
             ($urandom_range(0, 199) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
